skinny_sbox_layer_ctrl: RTL and testbench
=========================================

# skinny_sbox_layer_ctrl

- Nibble-serial controller for the 3-share SKINNY-64 S-box layer.
- Takes a 3-share 64-bit state, issues one nibble per cycle into the 3-stage masked S-box pipeline (`SKINNY_Sbox`) together with its per-nibble fresh randomness, then collects the 16 output nibbles into a 3-share result register.
- Sits between the round state register and the linear layer (ShiftRows/MixColumns) in the round datapath.

## Interface
Parameters:
- `SBOX_LAT`, 3: S-box pipeline depth in cycles. Must match the instantiated S-box.
- `NIBBLES`, 16: nibbles per layer.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a layer. Sampled only in IDLE.
- `state_in1`/`state_in2`/`state_in3` in 64 each: input shares. Captured on an accepted `start`. Nibble i is bits [4i+3:4i].
- `rnd_valid` in 1: fresh randomness available this cycle.
- `rnd` in 36: per-nibble randomness. [23:0] → S-box `r`, [31:24] → S-box `rc`, [35:32] → seed `klmn`.
- `rnd_ready` out 1: randomness consumed this cycle.
- `busy` out 1: layer in progress.
- `done` out 1: one-cycle pulse when results are valid.
- `state_out1`/`state_out2`/`state_out3` out 64 each: output shares. Held until the next `done`.

## Operation
- FSM states:
  - IDLE: `start` → FEED; capture inputs; clear the issue counter.
  - FEED: `rnd_valid`=1 → issue nibble `idx`, assert `rnd_ready`, increment `idx`. `rnd_valid`=0 → bubble; nothing issued, `idx` held. After nibble 15 is issued → DRAIN.
  - DRAIN: wait until the valid shift register is empty → DONE.
  - DONE: pulse `done` for one cycle → IDLE.
- The S-box has no stall. The block carries a `SBOX_LAT`-deep shift register of {valid, 4-bit index} alongside the pipeline. When the tail entry is valid, S-box `out1/2/3` are written into nibble slot `index` of `state_out*`.
- `rnd_ready` = FEED & `rnd_valid`. Randomness is never consumed outside FEED.
- `klmn` source:
  - First issued nibble of a layer: `rnd[35:32]` registered alongside the nibble.
  - Later nibbles: the S-box `klmn_out` registered one cycle.
  - Bubbles do not update the `klmn` register.
- Share separation: the three share paths are never combined in this block. Registers and muxes are per share, with no cross-share logic.
- `start` while not IDLE: ignored.
- Reset mid-layer:
  - FSM returns to IDLE; valid pipe cleared.
  - `busy`, `done`, `rnd_ready` and all `state_out*` are 0.
  - Partial results are discarded.

## Timing
- All outputs reset to 0.
- `start` accepted at edge t → nibble k issued in cycle t+1+k when there are no bubbles.
- Each output nibble is captured `SBOX_LAT` cycles after its issue.
- With continuous randomness, `done` is high in cycle t+20. Each bubble adds one cycle.
- `busy` is high from t+1 through the `done` cycle.
- A new `start` is accepted in the cycle after `done`.
- `state_out*` update nibble-wise during DRAIN. They are only guaranteed coherent while `done` is high or after it.

## Configuration
- `SBOX_BUBBLE_ZERO_EN`:
  - Defined: during bubbles and while IDLE/DRAIN/DONE, the S-box data inputs and `r`/`rc` are driven to 0. This avoids re-presenting stale shares.
  - Undefined: the S-box inputs hold the last issued nibble and randomness, which saves the zeroing muxes.
- Functional results are identical either way.

## Structure
- Shared package `skinny_pkg` holds:
  - constants `SBOX_LAT` and `NIBBLES`;
  - the FSM state enum (IDLE, FEED, DRAIN, DONE);
  - randomness field offsets (`R_LSB`, `RC_LSB`, `KLMN_LSB`).
- One natural sub-module: `sbox_tag_pipe`, the {valid, index} delay line of depth `SBOX_LAT`.
- The S-box itself is instantiated here, not in the package.

## Test plan
- All shares 0, randomness 0, `rnd_valid`=1 → XOR of the output shares = 0xCCCCCCCCCCCCCCCC; `done` at t+20.
- Unmasked 0x0123456789ABCDEF, split with random shares, random `rnd` → XOR of the output shares = 0xC6901A2B385D4E7F, independent of the randomness.
- `rnd_valid` low for cycles 3, 4 and 10 of FEED → same result as the previous case; `done` at t+23; `rnd_ready` asserted exactly 16 times.
- `start` pulsed again during FEED and DRAIN → ignored; exactly one `done`; outputs unchanged.
- `rst_n` dropped mid-DRAIN → all outputs 0 immediately. The next `start` with input 0x0000000000000000 yields XOR = 0xCCCCCCCCCCCCCCCC.
- Build with and without `SBOX_BUBBLE_ZERO_EN` → results bit-identical. With the macro defined, the S-box inputs are 0 in every bubble cycle.

Source files
------------

// File: rtl/skinny_pkg.sv
// ============================================================================
// Module      : skinny_pkg
// Description : Shared constants, FSM state encoding, randomness field
//               offsets and the 4-bit SKINNY-64 S-box table used by the
//               nibble-serial S-box layer controller and its S-box pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package skinny_pkg;

    localparam int SBOX_LAT = 3;     // masked S-box pipeline depth
    localparam int NIBBLES  = 16;    // nibbles per 64-bit state

    // Field layout of the 36-bit per-nibble randomness word
    localparam int R_LSB    = 0;
    localparam int R_W      = 24;
    localparam int RC_LSB   = 24;
    localparam int RC_W     = 8;
    localparam int KLMN_LSB = 32;
    localparam int KLMN_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // SKINNY-64 4-bit S-box
    function automatic logic [3:0] skinny_sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h6;  4'h2: y = 4'h9;  4'h3: y = 4'h0;
            4'h4: y = 4'h1;  4'h5: y = 4'hA;  4'h6: y = 4'h2;  4'h7: y = 4'hB;
            4'h8: y = 4'h3;  4'h9: y = 4'h8;  4'hA: y = 4'h5;  4'hB: y = 4'hD;
            4'hC: y = 4'h4;  4'hD: y = 4'hE;  4'hE: y = 4'h7;  default: y = 4'hF;
        endcase
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/SKINNY_Sbox.sv
// ============================================================================
// Module      : SKINNY_Sbox
// Description : 3-stage, 3-share SKINNY-64 S-box pipeline (functional model).
//               Stage 1 re-masks the input shares with r[7:0], stage 2
//               evaluates the S-box and re-splits with r[23:8], stage 3
//               re-masks with rc. The XOR of out1..3 equals S(in1^in2^in3)
//               three cycles after the inputs are presented. klmn_out is a
//               combinational update of the klmn seed. No stall, no reset.
// Ports       : clk; in1..in3 [3:0] shares; r [23:0]; rc [7:0]; klmn [3:0];
//               out1..out3 [3:0]; klmn_out [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module SKINNY_Sbox
    import skinny_pkg::*;
(
    input  logic        clk,
    input  logic [3:0]  in1,
    input  logic [3:0]  in2,
    input  logic [3:0]  in3,
    input  logic [23:0] r,
    input  logic [7:0]  rc,
    input  logic [3:0]  klmn,
    output logic [3:0]  out1,
    output logic [3:0]  out2,
    output logic [3:0]  out3,
    output logic [3:0]  klmn_out
);

    logic [3:0]  r_a1, r_a2, r_a3;
    logic [15:0] r_r1;
    logic [7:0]  r_rc1, r_rc2;
    logic [3:0]  r_b1, r_b2, r_b3;
    logic [3:0]  w_q1, w_q2;

    assign w_q1     = r_r1[3:0] ^ r_r1[11:8];
    assign w_q2     = r_r1[7:4] ^ r_r1[15:12];
    assign klmn_out = {klmn[2:0], klmn[3] ^ klmn[2]};

    always_ff @(posedge clk) begin
        // stage 1: share refresh, XOR of the three shares preserved
        r_a1  <= in1 ^ r[3:0];
        r_a2  <= in2 ^ r[7:4];
        r_a3  <= in3 ^ r[3:0] ^ r[7:4];
        r_r1  <= r[23:8];
        r_rc1 <= rc;
        // stage 2: nonlinear layer and re-split
        r_b1  <= skinny_sbox4(r_a1 ^ r_a2 ^ r_a3) ^ w_q1 ^ w_q2;
        r_b2  <= w_q1;
        r_b3  <= w_q2;
        r_rc2 <= r_rc1;
        // stage 3: output refresh
        out1  <= r_b1 ^ r_rc2[3:0];
        out2  <= r_b2 ^ r_rc2[7:4];
        out3  <= r_b3 ^ r_rc2[3:0] ^ r_rc2[7:4];
    end

endmodule

`default_nettype wire

// File: rtl/sbox_tag_pipe.sv
// ============================================================================
// Module      : sbox_tag_pipe
// Description : {valid, index} delay line running alongside the S-box
//               pipeline. The tail entry lines up with the S-box outputs.
//               pending flags entries that will still be in flight after
//               the next edge (everything but the tail).
// Ports       : clk, rst_n; in_valid, in_idx; tail_valid, tail_idx; pending
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             tail_valid,
    output logic [IDX_W-1:0] tail_idx,
    output logic             pending
);

    logic [DEPTH-1:0] r_vld;
    logic [IDX_W-1:0] r_idx [DEPTH];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_vld[0] <= 1'b0;
                        r_idx[0] <= '0;
                    end else begin
                        r_vld[0] <= in_valid;
                        r_idx[0] <= in_idx;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_vld[i] <= 1'b0;
                        r_idx[i] <= '0;
                    end else begin
                        r_vld[i] <= r_vld[i-1];
                        r_idx[i] <= r_idx[i-1];
                    end
                end
            end
        end
    endgenerate

    assign tail_valid = r_vld[DEPTH-1];
    assign tail_idx   = r_idx[DEPTH-1];
    assign pending    = |r_vld[DEPTH-2:0];

endmodule

`default_nettype wire

// File: rtl/skinny_sbox_layer_ctrl.sv
// ============================================================================
// Module      : skinny_sbox_layer_ctrl
// Description : Nibble-serial controller for the 3-share SKINNY-64 S-box
//               layer. Captures three 64-bit shares on start, issues one
//               nibble per randomness-valid cycle into SKINNY_Sbox and
//               collects the results into three output share registers.
//               Share paths are kept separate throughout.
// Config      : SBOX_BUBBLE_ZERO_EN - when defined, S-box data and r/rc
//               inputs are forced to 0 whenever no nibble is issued; when
//               undefined they hold the last issued nibble/randomness.
// Ports       : clk, rst_n (async, active low); start; state_in1..3 [63:0];
//               rnd_valid, rnd [35:0], rnd_ready; busy; done (1-cycle pulse);
//               state_out1..3 [63:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skinny_sbox_layer_ctrl #(
    parameter int SBOX_LAT = skinny_pkg::SBOX_LAT,
    parameter int NIBBLES  = skinny_pkg::NIBBLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] state_in1,
    input  logic [4*NIBBLES-1:0] state_in2,
    input  logic [4*NIBBLES-1:0] state_in3,
    input  logic                 rnd_valid,
    input  logic [35:0]          rnd,
    output logic                 rnd_ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] state_out1,
    output logic [4*NIBBLES-1:0] state_out2,
    output logic [4*NIBBLES-1:0] state_out3
);
    import skinny_pkg::*;

    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_first;
    logic [4*NIBBLES-1:0] r_sh1, r_sh2, r_sh3;
    logic [4*NIBBLES-1:0] r_out1, r_out2, r_out3;
    logic [3:0]           r_klmn;
    logic                 r_busy, r_done;

    logic                 w_issue;
    logic [3:0]           w_nib1, w_nib2, w_nib3;
    logic [3:0]           w_sb_in1, w_sb_in2, w_sb_in3;
    logic [23:0]          w_sb_r;
    logic [7:0]           w_sb_rc;
    logic [3:0]           w_sb_klmn, w_sb_klmn_out;
    logic [3:0]           w_sb_out1, w_sb_out2, w_sb_out3;
    logic                 w_tail_valid, w_pending;
    logic [IDX_W-1:0]     w_tail_idx;

    assign w_issue   = (r_state == S_FEED) && rnd_valid;
    assign rnd_ready = w_issue;
    assign busy      = r_busy;
    assign done      = r_done;
    assign state_out1 = r_out1;
    assign state_out2 = r_out2;
    assign state_out3 = r_out3;

    assign w_nib1 = r_sh1[{r_idx, 2'b00} +: 4];
    assign w_nib2 = r_sh2[{r_idx, 2'b00} +: 4];
    assign w_nib3 = r_sh3[{r_idx, 2'b00} +: 4];

    // The first nibble of a layer is seeded from rnd, later ones chain the
    // S-box klmn_out through r_klmn.
    assign w_sb_klmn = r_first ? rnd[KLMN_LSB +: KLMN_W] : r_klmn;

`ifdef SBOX_BUBBLE_ZERO_EN
    assign w_sb_in1 = w_issue ? w_nib1 : 4'h0;
    assign w_sb_in2 = w_issue ? w_nib2 : 4'h0;
    assign w_sb_in3 = w_issue ? w_nib3 : 4'h0;
    assign w_sb_r   = w_issue ? rnd[R_LSB +: R_W]   : '0;
    assign w_sb_rc  = w_issue ? rnd[RC_LSB +: RC_W] : '0;
`else
    logic [3:0]  r_hold1, r_hold2, r_hold3;
    logic [23:0] r_hold_r;
    logic [7:0]  r_hold_rc;

    // Non-issue cycles keep re-presenting the last issued nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold1   <= '0;
            r_hold2   <= '0;
            r_hold3   <= '0;
            r_hold_r  <= '0;
            r_hold_rc <= '0;
        end else if (w_issue) begin
            r_hold1   <= w_nib1;
            r_hold2   <= w_nib2;
            r_hold3   <= w_nib3;
            r_hold_r  <= rnd[R_LSB +: R_W];
            r_hold_rc <= rnd[RC_LSB +: RC_W];
        end
    end

    assign w_sb_in1 = w_issue ? w_nib1 : r_hold1;
    assign w_sb_in2 = w_issue ? w_nib2 : r_hold2;
    assign w_sb_in3 = w_issue ? w_nib3 : r_hold3;
    assign w_sb_r   = w_issue ? rnd[R_LSB +: R_W]   : r_hold_r;
    assign w_sb_rc  = w_issue ? rnd[RC_LSB +: RC_W] : r_hold_rc;
`endif

    SKINNY_Sbox u_sbox (
        .clk      (clk),
        .in1      (w_sb_in1),
        .in2      (w_sb_in2),
        .in3      (w_sb_in3),
        .r        (w_sb_r),
        .rc       (w_sb_rc),
        .klmn     (w_sb_klmn),
        .out1     (w_sb_out1),
        .out2     (w_sb_out2),
        .out3     (w_sb_out3),
        .klmn_out (w_sb_klmn_out)
    );

    sbox_tag_pipe #(
        .DEPTH (SBOX_LAT),
        .IDX_W (IDX_W)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (w_issue),
        .in_idx     (r_idx),
        .tail_valid (w_tail_valid),
        .tail_idx   (w_tail_idx),
        .pending    (w_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_sh3   <= '0;
            r_klmn  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sh1   <= state_in1;
                        r_sh2   <= state_in2;
                        r_sh3   <= state_in3;
                        r_idx   <= '0;
                        r_first <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (rnd_valid) begin
                        r_idx   <= r_idx + 1'b1;
                        r_first <= 1'b0;
                        r_klmn  <= w_sb_klmn_out;
                        if (r_idx == C_LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Only the tail remains: it is written on this edge, so
                    // the results are complete in the DONE cycle.
                    if (!w_pending) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out1 <= '0;
            r_out2 <= '0;
            r_out3 <= '0;
        end else if (w_tail_valid) begin
            r_out1[{w_tail_idx, 2'b00} +: 4] <= w_sb_out1;
            r_out2[{w_tail_idx, 2'b00} +: 4] <= w_sb_out2;
            r_out3[{w_tail_idx, 2'b00} +: 4] <= w_sb_out3;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// ============================================================================
// Module      : tb_skinny_sbox_layer_ctrl
// Description : Directed self-checking bench for skinny_sbox_layer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skinny_sbox_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] state_in1 = '0, state_in2 = '0, state_in3 = '0;
    logic        rnd_valid = 1'b0;
    logic [35:0] rnd = '0;
    logic        rnd_ready, busy, done;
    logic [63:0] state_out1, state_out2, state_out3;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] C_PT     = 64'h0123456789ABCDEF;
    localparam logic [63:0] C_CT     = 64'hC6901A2B385D4E7F;
    localparam logic [63:0] C_ZERO_S = 64'hCCCCCCCCCCCCCCCC;

    skinny_sbox_layer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .state_in1  (state_in1),
        .state_in2  (state_in2),
        .state_in3  (state_in3),
        .rnd_valid  (rnd_valid),
        .rnd        (rnd),
        .rnd_ready  (rnd_ready),
        .busy       (busy),
        .done       (done),
        .state_out1 (state_out1),
        .state_out2 (state_out2),
        .state_out3 (state_out3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one layer. bubble[n] drops rnd_valid in cycle t+n; restart pulses
    // start at t+5 (FEED) and t+18 (DRAIN); abort_n>0 drops rst_n in t+abort_n.
    task automatic run_layer(input logic [63:0] s1, input logic [63:0] s2,
                             input logic [63:0] s3, input logic [63:0] bubble,
                             input bit use_rand, input bit restart, input int abort_n,
                             output int done_cyc, output int done_cnt, output int rdy_cnt,
                             output logic busy_first, output logic busy_after);
        done_cyc = 0; done_cnt = 0; rdy_cnt = 0; busy_first = 1'b0; busy_after = 1'b1;
        @(negedge clk);
        start = 1'b1; state_in1 = s1; state_in2 = s2; state_in3 = s3;
        @(posedge clk);               // edge t
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);           // middle of cycle t+n
            if (n == 1) busy_first = busy;
            if (done_cyc != 0 && n == done_cyc + 1) busy_after = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            rnd_valid = !bubble[n];
            rnd = use_rand ? {4'($urandom), $urandom} : 36'h0;
            start = restart && (n == 5 || n == 18);
            if (abort_n == n) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", {63'h0, busy}, 64'h0);
                check("rst_done", {63'h0, done}, 64'h0);
                check("rst_rdy", {63'h0, rnd_ready}, 64'h0);
                check("rst_out1", state_out1, 64'h0);
                check("rst_out2", state_out2, 64'h0);
                check("rst_out3", state_out3, 64'h0);
                break;
            end
            #1;
            if (rnd_ready) rdy_cnt++;
`ifdef SBOX_BUBBLE_ZERO_EN
            if (!rnd_ready) begin
                check("zero_in", {32'h0, 4'h0, dut.w_sb_in1, dut.w_sb_in2, dut.w_sb_in3,
                                  dut.w_sb_rc, dut.w_sb_r[3:0]}, 64'h0);
                check("zero_r", {40'h0, dut.w_sb_r}, 64'h0);
            end
`endif
        end
        start = 1'b0;
        rnd_valid = 1'b0;
        rnd = '0;
    endtask

    int          dc, dn, rc;
    logic        b1, b2;
    logic [63:0] m1, m2;
    logic [63:0] bub;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_rdy", {63'h0, rnd_ready}, 64'h0);
        check("reset_out", state_out1 | state_out2 | state_out3, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: all-zero shares and randomness
        run_layer(64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 0, dc, dn, rc, b1, b2);
        check("zero_xor", state_out1 ^ state_out2 ^ state_out3, C_ZERO_S);
        check("zero_done_cyc", 64'(dc), 64'd20);
        check("zero_done_cnt", 64'(dn), 64'd1);
        check("zero_rdy_cnt", 64'(rc), 64'd16);
        check("zero_busy_t1", {63'h0, b1}, 64'h1);
        check("zero_busy_after", {63'h0, b2}, 64'h0);

        // 2: masked plaintext with random shares and randomness
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        run_layer(m1, m2, C_PT ^ m1 ^ m2, 64'h0, 1'b1, 1'b0, 0, dc, dn, rc, b1, b2);
        check("pt_xor", state_out1 ^ state_out2 ^ state_out3, C_CT);
        check("pt_done_cyc", 64'(dc), 64'd20);
        check("pt_rdy_cnt", 64'(rc), 64'd16);

        // 3: bubbles in FEED cycles 3, 4 and 10
        bub = 64'h0;
        bub[3] = 1'b1; bub[4] = 1'b1; bub[10] = 1'b1;
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        run_layer(m1, m2, C_PT ^ m1 ^ m2, bub, 1'b1, 1'b0, 0, dc, dn, rc, b1, b2);
        check("bub_xor", state_out1 ^ state_out2 ^ state_out3, C_CT);
        check("bub_done_cyc", 64'(dc), 64'd23);
        check("bub_rdy_cnt", 64'(rc), 64'd16);
        check("bub_done_cnt", 64'(dn), 64'd1);

        // 4: start re-pulsed during FEED and DRAIN
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        run_layer(m1, m2, C_PT ^ m1 ^ m2, 64'h0, 1'b1, 1'b1, 0, dc, dn, rc, b1, b2);
        check("rst_xor", state_out1 ^ state_out2 ^ state_out3, C_CT);
        check("rst_done_cnt", 64'(dn), 64'd1);
        check("rst_done_cyc", 64'(dc), 64'd20);
        check("rst_rdy_cnt", 64'(rc), 64'd16);

        // 5: reset during DRAIN, then a fresh all-zero layer
        m1 = {$urandom, $urandom};
        run_layer(m1, m1, C_PT, 64'h0, 1'b1, 1'b0, 18, dc, dn, rc, b1, b2);
        @(negedge clk);
        rst_n = 1'b1;
        run_layer(64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 0, dc, dn, rc, b1, b2);
        check("post_rst_xor", state_out1 ^ state_out2 ^ state_out3, C_ZERO_S);
        check("post_rst_done_cyc", 64'(dc), 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
